// File: rtl/keypad_scan_if.sv
// Keypad pins plus key report: the scan controller is the master,
// the pad/consumer side is the slave.
interface keypad_scan_if;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [1:0] col_idx;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  rows,
      output cols, col_idx, key_code, key_valid, key_held
   );

   modport slave (
      output rows,
      input  cols, col_idx, key_code, key_valid, key_held
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: strobes columns, synchronises/debounces rows, reports one code per press.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
//
// state    | meaning
// SCAN     | strobing columns, rows sampled at the end of each column slot
// DEBOUNCE | candidate row latched, column frozen, waiting for a stable press
// HELD     | key accepted, waiting for the latched row to go high
// RELEASE  | latched row high, waiting for a stable release
module keypad_scan_ctrl #(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CNT = 1000
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_CNT   = 50000
`endif
) (
   input logic           clock,
   input logic           reset,
   keypad_scan_if.master kp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CNT);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);
   // The HELD edge that sees the row high is the first of the release samples.
   localparam logic [DEB_W-1:0] REL_LAST = DEB_W'(DEBOUNCE_CNT - 2);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t           state;
   logic [3:0]       rows_m;
   logic [3:0]       rows_s;
   logic [3:0]       cols;
   logic [1:0]       col_idx;
   logic [1:0]       row_sel;
   logic [3:0]       key_code;
   logic             key_valid;
   logic             key_held;
   logic [DIV_W-1:0] div;
   logic [DEB_W-1:0] deb;

`ifdef KEY_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CNT);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
   logic [REP_W-1:0] rep;
`endif

   logic       row_bit;
   logic [1:0] col_nx;
   logic [3:0] cols_nx;
   logic [1:0] first_low;

   always_comb begin
      row_bit = rows_s[row_sel];
      col_nx  = col_idx + 2'd1;
      cols_nx = ~(4'b0001 << col_nx);
      if (!rows_s[0])      first_low = 2'd0;
      else if (!rows_s[1]) first_low = 2'd1;
      else if (!rows_s[2]) first_low = 2'd2;
      else                 first_low = 2'd3;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= SCAN;
         rows_m    <= 4'hF;
         rows_s    <= 4'hF;
         col_idx   <= 2'd0;
         cols      <= 4'b1110;
         row_sel   <= 2'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         div       <= '0;
         deb       <= '0;
`ifdef KEY_REPEAT_EN
         rep       <= '0;
`endif
      end else begin
         rows_m    <= kp.rows;
         rows_s    <= rows_m;
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               if (div == DIV_LAST) begin
                  div <= '0;
                  if (rows_s == 4'hF) begin
                     col_idx <= col_nx;
                     cols    <= cols_nx;
                  end else begin
                     row_sel <= first_low;
                     deb     <= '0;
                     state   <= DEBOUNCE;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (row_bit) begin
                  col_idx <= col_nx;
                  cols    <= cols_nx;
                  div     <= '0;
                  state   <= SCAN;
               end else if (deb == DEB_LAST) begin
                  // Code = row*4 + col + 1, so row3/col3 wraps to 0.
                  key_code  <= {row_sel, col_idx} + 4'd1;
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  state     <= HELD;
`ifdef KEY_REPEAT_EN
                  rep       <= '0;
`endif
               end else begin
                  deb <= deb + 1'b1;
               end
            end
            HELD: begin
               if (row_bit) begin
                  deb   <= '0;
                  state <= RELEASE;
`ifdef KEY_REPEAT_EN
                  rep   <= '0;
               end else if (rep == REP_LAST) begin
                  key_valid <= 1'b1;
                  rep       <= '0;
               end else begin
                  rep <= rep + 1'b1;
`endif
               end
            end
            RELEASE: begin
               if (!row_bit) begin
                  deb   <= '0;
                  state <= HELD;
               end else if (deb == REL_LAST) begin
                  key_held <= 1'b0;
                  col_idx  <= col_nx;
                  cols     <= cols_nx;
                  div      <= '0;
                  state    <= SCAN;
               end else begin
                  deb <= deb + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   assign kp.cols      = cols;
   assign kp.col_idx   = col_idx;
   assign kp.key_code  = key_code;
   assign kp.key_valid = key_valid;
   assign kp.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a key-matrix model drives rows from cols; expected timing is
// derived arithmetically from the scan slot length, the 2-flop sync delay and the debounce count.
module tb_keypad_scan_ctrl;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
   localparam int REP      = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] keys  = '0;   // bit r*4+c = key at row r, column c pressed
   int          cyc   = 0;
   int          n_assert = 0;
   int          n_fail   = 0;
   int          last_acc = 0;

   keypad_scan_if kb ();

   keypad_scan_ctrl #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_CNT(DEB)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_CNT(REP)
`endif
   ) dut (
      .clock(clock),
      .reset(reset),
      .kp(kb)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

   always_comb begin
      kb.rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !kb.cols[c]) kb.rows[r] = 1'b0;
   end

   function automatic logic [3:0] key_map(input int r, input int c);
      return 4'((r*4 + c + 1) % 16);
   endfunction

   // Edge on which a key in column c is first sampled, given scanning from column s with a fresh slot at t.
   function automatic int detect_cyc(input int t, input int s, input int c);
      return t + SCAN_DIV * (((c - s) & 3) + 1);
   endfunction

   function automatic logic [3:0] col_strobe(input int c);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << c);
   endfunction

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic goto_cyc(input int k);
      while (cyc < k) cycle();
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int ec;
      keys = '0;
      apply_reset(2);
      n_assert++;
      if (kb.cols !== 4'b1110 || kb.col_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_cols: cols=%b col_idx=%0d required cols=1110 col_idx=0", kb.cols, kb.col_idx);
      end
      n_assert++;
      if ({kb.key_code, kb.key_valid, kb.key_held} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_keys: code=%h valid=%b held=%b required all 0", kb.key_code, kb.key_valid, kb.key_held);
      end
      for (int i = 1; i <= 16; i++) begin
         cycle();
         ec = (i / SCAN_DIV) % 4;
         n_assert++;
         if (kb.col_idx !== 2'(ec) || kb.cols !== col_strobe(ec) || kb.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL free_scan cyc %0d: col_idx=%0d cols=%b valid=%b required col_idx=%0d cols=%b valid=0",
                     cyc, kb.col_idx, kb.cols, kb.key_valid, ec, col_strobe(ec));
         end
      end
   endtask

   task automatic test_single_press();
      int acc, pulses;
      keys = '0;
      keys[1*4+2] = 1'b1;
      apply_reset(1);
      acc = detect_cyc(0, 0, 2) + DEB;
      pulses = 0;
      while (cyc < 30) begin
         cycle();
         if (kb.key_valid) pulses++;
         if (cyc == acc - 1) begin
            n_assert++;
            if (kb.key_valid !== 1'b0 || kb.key_held !== 1'b0) begin
               n_fail++;
               $display("FAIL press_early: valid=%b held=%b at cyc %0d required 0 0", kb.key_valid, kb.key_held, cyc);
            end
         end
         if (cyc == acc) begin
            n_assert++;
            if (kb.key_valid !== 1'b1 || kb.key_code !== 4'h7 || kb.key_held !== 1'b1) begin
               n_fail++;
               $display("FAIL press_accept: valid=%b code=%h held=%b required 1 7 1", kb.key_valid, kb.key_code, kb.key_held);
            end
         end
      end
      n_assert++;
      if (pulses != 1 || kb.col_idx !== 2'd2 || kb.cols !== 4'b1011 || kb.key_held !== 1'b1) begin
         n_fail++;
         $display("FAIL press_frozen: pulses=%0d col_idx=%0d cols=%b held=%b required 1 2 1011 1",
                  pulses, kb.col_idx, kb.cols, kb.key_held);
      end
   endtask

   task automatic test_release_bounce();
      int ea, eb, pulses, drops;
      pulses = 0;
      drops  = 0;
      ea = cyc;
      keys = '0;
      goto_cyc(ea + 3);
      keys[1*4+2] = 1'b1;
      while (cyc < ea + 13) begin
         cycle();
         if (kb.key_valid) pulses++;
         if (!kb.key_held) drops++;
      end
      n_assert++;
      if (pulses != 0 || drops != 0) begin
         n_fail++;
         $display("FAIL bounce_in_held: extra pulses=%0d held drops=%0d required 0 0", pulses, drops);
      end
      eb = cyc;
      keys = '0;
      while (cyc < eb + 2 + DEB) begin
         cycle();
         if (kb.key_valid) pulses++;
         if (cyc == eb + 1 + DEB) begin
            n_assert++;
            if (kb.key_held !== 1'b1) begin
               n_fail++;
               $display("FAIL release_early: held=%b required 1", kb.key_held);
            end
         end
      end
      n_assert++;
      if (kb.key_held !== 1'b0 || kb.col_idx !== 2'd3 || pulses != 0) begin
         n_fail++;
         $display("FAIL release_done: held=%b col_idx=%0d pulses=%0d required 0 3 0", kb.key_held, kb.col_idx, pulses);
      end
   endtask

   task automatic test_debounce_abort();
      int t, det, pulses;
      pulses = 0;
      t = cyc;
      keys = '0;
      keys[1*4+2] = 1'b1;
      det = detect_cyc(t, 3, 2);
      goto_cyc(det + 1);
      keys = '0;
      while (cyc < det + 4) begin
         cycle();
         if (kb.key_valid) pulses++;
         if (cyc == det + 3) begin
            n_assert++;
            if (kb.col_idx !== 2'd2) begin
               n_fail++;
               $display("FAIL abort_frozen: col_idx=%0d required 2", kb.col_idx);
            end
         end
      end
      n_assert++;
      if (pulses != 0 || kb.key_code !== 4'h7 || kb.key_held !== 1'b0 || kb.col_idx !== 2'd3) begin
         n_fail++;
         $display("FAIL abort_resume: pulses=%0d code=%h held=%b col_idx=%0d required 0 7 0 3",
                  pulses, kb.key_code, kb.key_held, kb.col_idx);
      end
   endtask

   task automatic test_second_press();
      int t, acc, pulses;
      pulses = 0;
      t = cyc;
      keys = '0;
      keys[3*4+3] = 1'b1;
      acc = detect_cyc(t, 3, 3) + DEB;
      while (cyc < acc + 2) begin
         cycle();
         if (kb.key_valid) pulses++;
         if (cyc == acc - 1) begin
            n_assert++;
            if (kb.key_code !== 4'h7) begin
               n_fail++;
               $display("FAIL second_hold_code: code=%h required 7", kb.key_code);
            end
         end
         if (cyc == acc) begin
            n_assert++;
            if (kb.key_valid !== 1'b1 || kb.key_code !== 4'h0 || kb.key_held !== 1'b1) begin
               n_fail++;
               $display("FAIL second_accept: valid=%b code=%h held=%b required 1 0 1", kb.key_valid, kb.key_code, kb.key_held);
            end
         end
      end
      n_assert++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL second_pulses: got %0d required 1", pulses);
      end
   endtask

   task automatic test_reset_in_held();
      int acc, pulses;
      pulses = 0;
      apply_reset(1);
      n_assert++;
      if (kb.cols !== 4'b1110 || kb.col_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL held_reset_cols: cols=%b col_idx=%0d required 1110 0", kb.cols, kb.col_idx);
      end
      n_assert++;
      if ({kb.key_code, kb.key_valid, kb.key_held} !== 6'b0) begin
         n_fail++;
         $display("FAIL held_reset_keys: code=%h valid=%b held=%b required 0 0 0", kb.key_code, kb.key_valid, kb.key_held);
      end
      acc = detect_cyc(0, 0, 3) + DEB;
      while (cyc < acc) begin
         cycle();
         if (kb.key_valid && cyc < acc) pulses++;
         if (cyc == acc - 1) begin
            n_assert++;
            if (kb.key_held !== 1'b0 || pulses != 0) begin
               n_fail++;
               $display("FAIL redetect_early: held=%b pulses=%0d required 0 0", kb.key_held, pulses);
            end
         end
      end
      n_assert++;
      if (kb.key_valid !== 1'b1 || kb.key_held !== 1'b1 || kb.key_code !== 4'h0) begin
         n_fail++;
         $display("FAIL redetect: valid=%b held=%b code=%h required 1 1 0", kb.key_valid, kb.key_held, kb.key_code);
      end
      last_acc = acc;
   endtask

   task automatic test_repeat();
      int exp_q[$];
      int got_q[$];
      int r, stray;
      stray = 0;
`ifdef KEY_REPEAT_EN
      for (int k = 1; last_acc + k*REP <= last_acc + 100; k++) exp_q.push_back(last_acc + k*REP);
`endif
      while (cyc < last_acc + 100) begin
         cycle();
         if (kb.key_valid) got_q.push_back(cyc);
      end
      n_assert++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL repeat_count: got %0d pulses required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_assert++;
         if (got_q[i] != exp_q[i]) begin
            n_fail++;
            $display("FAIL repeat_time %0d: pulse at cyc %0d required %0d", i, got_q[i], exp_q[i]);
         end
      end
      keys = '0;
      r = cyc;
      while (cyc < r + 2 + DEB) begin
         cycle();
         if (kb.key_valid) stray++;
      end
      n_assert++;
      if (kb.key_held !== 1'b0 || kb.col_idx !== 2'd0 || stray != 0 || kb.key_code !== 4'h0) begin
         n_fail++;
         $display("FAIL repeat_release: held=%b col_idx=%0d stray=%0d code=%h required 0 0 0 0",
                  kb.key_held, kb.col_idx, stray, kb.key_code);
      end
   endtask

   task automatic test_random();
      int s, t, c, er, acc, hold, bounce, pulses, bad, r;
      logic [3:0]  m;
      logic [3:0]  ecode;
      logic [15:0] saved;
      s = 0;
      t = cyc;
      for (int it = 0; it < 10; it++) begin
         c  = $urandom_range(3);
         m  = 4'($urandom_range(1, 15));
         er = -1;
         keys = '0;
         for (int rr = 3; rr >= 0; rr--) begin
            if (m[rr]) begin
               keys[rr*4+c] = 1'b1;
               er = rr;
            end
         end
         ecode  = key_map(er, c);
         acc    = detect_cyc(t, s, c) + DEB;
         hold   = $urandom_range(5, 20);
         bounce = $urandom_range(0, 4);
         pulses = 0;
         bad    = 0;
         while (cyc < acc + hold) begin
            cycle();
            if (kb.key_valid) begin
               pulses++;
               if (cyc != acc || kb.key_code !== ecode) bad++;
            end
            if (cyc == acc + 1) keys[$urandom_range(3)*4 + ((c + 1) % 4)] = 1'b1;
         end
         n_assert++;
         if (pulses != 1 || bad != 0 || kb.key_held !== 1'b1 || kb.col_idx !== 2'(c) || kb.key_code !== ecode) begin
            n_fail++;
            $display("FAIL rand_press %0d: pulses=%0d bad=%0d held=%b col_idx=%0d code=%h required 1 0 1 %0d %h",
                     it, pulses, bad, kb.key_held, kb.col_idx, kb.key_code, c, ecode);
         end
         if (bounce > 0) begin
            saved = keys;
            keys  = '0;
            repeat (bounce) cycle();
            keys  = saved;
            pulses = 0;
            bad    = 0;
            repeat (10) begin
               cycle();
               if (kb.key_valid) pulses++;
               if (!kb.key_held) bad++;
            end
            n_assert++;
            if (pulses != 0 || bad != 0) begin
               n_fail++;
               $display("FAIL rand_bounce %0d: pulses=%0d held drops=%0d required 0 0", it, pulses, bad);
            end
         end
         keys   = '0;
         r      = cyc;
         pulses = 0;
         while (cyc < r + 2 + DEB) begin
            cycle();
            if (kb.key_valid) pulses++;
         end
         n_assert++;
         if (kb.key_held !== 1'b0 || kb.col_idx !== 2'((c + 1) % 4) || pulses != 0) begin
            n_fail++;
            $display("FAIL rand_release %0d: held=%b col_idx=%0d pulses=%0d required 0 %0d 0",
                     it, kb.key_held, kb.col_idx, pulses, (c + 1) % 4);
         end
         s = (c + 1) % 4;
         t = cyc;
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_release_bounce();
      test_debounce_abort();
      test_second_press();
      test_reset_in_held();
      test_repeat();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "time limit");
   end

endmodule
